// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame sequencer: state encoding and TX mux codes.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [1:0] MUX_START = 2'b00;
    localparam logic [1:0] MUX_STOP  = 2'b01;
    localparam logic [1:0] MUX_DATA  = 2'b10;
    localparam logic [1:0] MUX_PAR   = 2'b11;

    // Line source selected while sitting in a given state.
    function automatic logic [1:0] mux_decode(input state_t s);
        case (s)
            ST_START:  return MUX_START;
            ST_DATA:   return MUX_DATA;
            ST_PARITY: return MUX_PAR;
            default:   return MUX_STOP;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_bit_cnt.sv
// Clear/enable up-counter that saturates at TERMINAL and flags it; tracks data bits sent.
module uart_tx_bit_cnt #(
    parameter int WIDTH    = 3,
    parameter int TERMINAL = 7
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            count_reg <= '0;
        end else if (en && !tc) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tc = (count_reg == TC_VAL);

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit frame sequencer: start, data (LSB first), optional parity, 1..2 stop bits.
// One state cycle per bit time; back-to-back frames are accepted in the last stop cycle.
module uart_tx_fsm
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       DATA_VALID,
    input  logic       PAR_EN,
    output logic       ser_load,
    output logic       ser_shift,
    output logic       par_load,
    output logic [1:0] mux_sel,
    output logic       busy
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH);

    state_t     state_reg;
    state_t     state_next;
    logic       par_en_reg;
    logic       stop_cnt_reg;
    logic [1:0] mux_sel_reg;
    logic       busy_reg;
    logic       ser_shift_reg;

    logic accept;
    logic stop_last;
    logic bit_clr;
    logic bit_en;
    logic bit_tc;

    uart_tx_bit_cnt #(
        .WIDTH    (BIT_CNT_W),
        .TERMINAL (DATA_WIDTH - 1)
    ) u_bit_cnt (
        .clk  (CLK),
        .srst (RST),
        .clr  (bit_clr),
        .en   (bit_en),
        .tc   (bit_tc)
    );

    assign stop_last = (stop_cnt_reg == 1'(STOP_BITS - 1));
    assign accept    = DATA_VALID &&
                       ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && stop_last));

    always_comb begin
        state_next = state_reg;
        bit_clr    = 1'b1;
        bit_en     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = ST_START;
            end
            ST_START: begin
                state_next = ST_DATA;
            end
            ST_DATA: begin
                bit_clr = 1'b0;
                bit_en  = 1'b1;
                if (bit_tc) state_next = par_en_reg ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                state_next = ST_STOP;
            end
            ST_STOP: begin
                if (stop_last) state_next = accept ? ST_START : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Moore outputs are registered from the next state so they line up with state_reg.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= ST_IDLE;
            par_en_reg    <= 1'b0;
            stop_cnt_reg  <= 1'b0;
            mux_sel_reg   <= MUX_STOP;
            busy_reg      <= 1'b0;
            ser_shift_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) par_en_reg <= PAR_EN;
            if ((state_reg == ST_STOP) && !stop_last) begin
                stop_cnt_reg <= stop_cnt_reg + 1'b1;
            end else begin
                stop_cnt_reg <= 1'b0;
            end
            mux_sel_reg   <= mux_decode(state_next);
            busy_reg      <= (state_next != ST_IDLE);
            ser_shift_reg <= (state_next == ST_DATA);
        end
    end

    assign ser_load  = accept;
    assign par_load  = accept;
    assign mux_sel   = mux_sel_reg;
    assign busy      = busy_reg;
    assign ser_shift = ser_shift_reg;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench: three sequencer configurations share stimulus; each is compared per
// cycle against a frame-position model (position within a frame of computed length).
module tb_uart_tx_fsm;

    localparam int NDUT = 3;
    localparam int DWV [NDUT] = '{8, 8, 5};
    localparam int SBV [NDUT] = '{1, 2, 2};

    logic clk = 1'b0;
    logic rst;
    logic dv;
    logic pen;

    logic       sl [NDUT];
    logic       sh [NDUT];
    logic       pl [NDUT];
    logic       bz [NDUT];
    logic [1:0] ms [NDUT];

    int pos  [NDUT];
    int flen [NDUT];
    int parv [NDUT];
    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    uart_tx_fsm #(.DATA_WIDTH(8), .STOP_BITS(1)) dut0 (
        .CLK(clk), .RST(rst), .DATA_VALID(dv), .PAR_EN(pen),
        .ser_load(sl[0]), .ser_shift(sh[0]), .par_load(pl[0]), .mux_sel(ms[0]), .busy(bz[0])
    );
    uart_tx_fsm #(.DATA_WIDTH(8), .STOP_BITS(2)) dut1 (
        .CLK(clk), .RST(rst), .DATA_VALID(dv), .PAR_EN(pen),
        .ser_load(sl[1]), .ser_shift(sh[1]), .par_load(pl[1]), .mux_sel(ms[1]), .busy(bz[1])
    );
    uart_tx_fsm #(.DATA_WIDTH(5), .STOP_BITS(2)) dut2 (
        .CLK(clk), .RST(rst), .DATA_VALID(dv), .PAR_EN(pen),
        .ser_load(sl[2]), .ser_shift(sh[2]), .par_load(pl[2]), .mux_sel(ms[2]), .busy(bz[2])
    );

    task automatic chk(input string tag, input int idx, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s dut%0d cycle %0d: got %0d expected %0d", tag, idx, cyc, obs, exp);
    endtask

    // Expected line source from the bit position within the frame.
    function automatic int exp_mux(input int i);
        if (pos[i] < 0) return 1;
        if (pos[i] == 0) return 0;
        if (pos[i] <= DWV[i]) return 2;
        if (parv[i] != 0 && pos[i] == DWV[i] + 1) return 3;
        return 1;
    endfunction

    task automatic step(input bit d, input bit p, input bit r);
        bit acc [NDUT];
        dv  = d;
        pen = p;
        rst = r;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            acc[i] = d && (pos[i] < 0 || pos[i] == flen[i] - 1);
            chk("mux_sel", i, int'(ms[i]), exp_mux(i));
            chk("busy", i, int'(bz[i]), (pos[i] >= 0) ? 1 : 0);
            chk("ser_shift", i, int'(sh[i]), (pos[i] >= 1 && pos[i] <= DWV[i]) ? 1 : 0);
            chk("ser_load", i, int'(sl[i]), int'(acc[i]));
            chk("par_load", i, int'(pl[i]), int'(acc[i]));
        end
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) begin
            if (r) begin
                pos[i] = -1;
            end else if (acc[i]) begin
                pos[i]  = 0;
                parv[i] = p ? 1 : 0;
                flen[i] = 1 + DWV[i] + parv[i] + SBV[i];
            end else if (pos[i] >= 0) begin
                pos[i]++;
                if (pos[i] >= flen[i]) pos[i] = -1;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        dv  = 1'b0;
        pen = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            pos[i]  = -1;
            flen[i] = 0;
            parv[i] = 0;
        end
        @(negedge clk);
        @(negedge clk);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Single frame without parity, then with parity.
        step(1'b1, 1'b0, 1'b0);
        idle(14);
        step(1'b1, 1'b1, 1'b0);
        idle(14);

        // Held request: back-to-back frames.
        for (int k = 0; k < 40; k++) step(1'b1, 1'b1, 1'b0);
        idle(14);

        // Requests during DATA and PARITY are ignored.
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(3);
        step(1'b1, 1'b0, 1'b0);
        idle(3);
        step(1'b1, 1'b0, 1'b0);
        idle(14);

        // Reset in the fourth DATA cycle, then a fresh frame.
        step(1'b1, 1'b1, 1'b0);
        idle(4);
        step(1'b0, 1'b0, 1'b1);
        idle(2);
        step(1'b1, 1'b0, 1'b0);
        idle(14);

        // Parity enable dropped mid-frame: latched value still governs.
        step(1'b1, 1'b1, 1'b0);
        idle(3);
        for (int k = 0; k < 10; k++) step(1'b0, k[0], 1'b0);
        idle(4);

        // Random traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 60) == 0));
        end
        idle(14);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
